// File: rtl/mem_arbiter.sv
// Two-requester round-robin memory arbiter.
// Each requester presents one read or write at a time. A winner is picked on
// every rising edge and issued to the memory as a registered command in the
// following cycle. Read data is returned one cycle after the read command.
module mem_arbiter #(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req0,
  input  logic              req1,
  input  logic              we0,
  input  logic              we1,
  input  logic [ADDR_W-1:0] addr0,
  input  logic [ADDR_W-1:0] addr1,
  input  logic [DATA_W-1:0] wdata0,
  input  logic [DATA_W-1:0] wdata1,
  output logic              gnt0,
  output logic              gnt1,
  output logic              rvalid0,
  output logic              rvalid1,
  output logic [DATA_W-1:0] rdata0,
  output logic [DATA_W-1:0] rdata1,
  output logic              mem_wr_en,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [ADDR_W-1:0] mem_rd_addr,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out
);

  // run_p0 is low on the first live edge after reset so no grant is issued there.
  logic              run_p0;
  // Requester granted most recently (1 after reset, so requester 0 wins the first tie).
  logic              last_gnt_p0;
  // Owner of the read currently on the memory command port (0 or 1).
  logic              rd_own_p1;

  logic              elig0;
  logic              elig1;
  logic              win0;
  logic              win1;
  logic              win_any;
  logic              win_we;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Arbitration: mask a requester during its own grant cycle, break ties round robin.
  always_comb begin
    elig0     = run_p0 & req0 & ~gnt0;
    elig1     = run_p0 & req1 & ~gnt1;
    win0      = 1'b0;
    win1      = 1'b0;
    if (elig0 && elig1) begin
      if (last_gnt_p0) win0 = 1'b1;
      else             win1 = 1'b1;
    end else if (elig0) begin
      win0 = 1'b1;
    end else if (elig1) begin
      win1 = 1'b1;
    end
    win_any   = win0 | win1;
    win_we    = win1 ? we1    : we0;
    win_addr  = win1 ? addr1  : addr0;
    win_wdata = win1 ? wdata1 : wdata0;
  end

  // ---- stage p1: grant and memory command issue; p2: read return ----
  // Control: grants, command enables, round-robin pointer and read-return tracking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      run_p0      <= 1'b0;
      last_gnt_p0 <= 1'b1;
      rd_own_p1   <= 1'b0;
      gnt0        <= 1'b0;
      gnt1        <= 1'b0;
      mem_wr_en   <= 1'b0;
      mem_rd_en   <= 1'b0;
      rvalid0     <= 1'b0;
      rvalid1     <= 1'b0;
    end else begin
      run_p0    <= 1'b1;
      gnt0      <= win0;
      gnt1      <= win1;
      mem_wr_en <= win_any & win_we;
      mem_rd_en <= win_any & ~win_we;
      if (win_any)           last_gnt_p0 <= win1;
      if (win_any & ~win_we) rd_own_p1   <= win1;
      rvalid0   <= mem_rd_en & ~rd_own_p1;
      rvalid1   <= mem_rd_en &  rd_own_p1;
    end
  end

  // Datapath: address/data registers load only when their command issues, else hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_wr_addr <= '0;
      mem_rd_addr <= '0;
      mem_data_in <= '0;
    end else begin
      if (win_any && win_we) begin
        mem_wr_addr <= win_addr;
        mem_data_in <= win_wdata;
      end
      if (win_any && !win_we) begin
        mem_rd_addr <= win_addr;
      end
    end
  end

  // Read data is steered to the owning requester only while its rvalid is high.
  assign rdata0 = rvalid0 ? mem_data_out : '0;
  assign rdata1 = rvalid1 ? mem_data_out : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: requester agents, a behavioural memory, a transaction
// level reference model and a per-cycle compare process, plus directed scenarios.
module tb_mem_arbiter;
  localparam int DW = 4;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [1:0]    req;
  logic [1:0]    we;
  logic [AW-1:0] addr  [2];
  logic [DW-1:0] wdata [2];
  logic          gnt0, gnt1, rvalid0, rvalid1;
  logic [DW-1:0] rdata0, rdata1;
  logic          mem_wr_en, mem_rd_en;
  logic [AW-1:0] mem_wr_addr, mem_rd_addr;
  logic [DW-1:0] mem_data_in;
  logic [DW-1:0] mem_data_out = '0;

  always #5 clk = ~clk;

  mem_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req[0]), .req1(req[1]), .we0(we[0]), .we1(we[1]),
    .addr0(addr[0]), .addr1(addr[1]), .wdata0(wdata[0]), .wdata1(wdata[1]),
    .gnt0(gnt0), .gnt1(gnt1), .rvalid0(rvalid0), .rvalid1(rvalid1),
    .rdata0(rdata0), .rdata1(rdata1),
    .mem_wr_en(mem_wr_en), .mem_rd_en(mem_rd_en),
    .mem_wr_addr(mem_wr_addr), .mem_rd_addr(mem_rd_addr),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural memory, not reset, initialised with a known pattern.
  logic [DW-1:0] mem  [16];
  logic [DW-1:0] smem [16];
  initial begin
    for (int i = 0; i < 16; i++) begin
      mem[i]  = 4'(i) ^ 4'hF;
      smem[i] = 4'(i) ^ 4'hF;
    end
  end
  always @(posedge clk) begin
    if (mem_wr_en) mem[mem_wr_addr] <= mem_data_in;
    if (mem_rd_en) mem_data_out <= mem[mem_rd_addr];
  end

  // Requester agents: hold the head transaction until granted, then present the next.
  typedef struct {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    int            life;   // 0 = wait for grant forever, n = drop after n sampled edges
  } txn_t;
  txn_t q0[$];
  txn_t q1[$];
  logic g0, g1;
  int   age0 = 0, age1 = 0;

  always @(posedge clk) begin
    g0 = gnt0;
    g1 = gnt1;
    #1;
    if (q0.size() > 0 && req[0]) begin
      if (g0) begin q0.delete(0); age0 = 0; end
      else begin
        age0++;
        if (q0[0].life != 0 && age0 >= q0[0].life) begin q0.delete(0); age0 = 0; end
      end
    end
    if (q1.size() > 0 && req[1]) begin
      if (g1) begin q1.delete(0); age1 = 0; end
      else begin
        age1++;
        if (q1[0].life != 0 && age1 >= q1[0].life) begin q1.delete(0); age1 = 0; end
      end
    end
    if (q0.size() > 0) begin
      req[0] = 1'b1; we[0] = q0[0].we; addr[0] = q0[0].addr; wdata[0] = q0[0].data;
    end else req[0] = 1'b0;
    if (q1.size() > 0) begin
      req[1] = 1'b1; we[1] = q1[0].we; addr[1] = q1[0].addr; wdata[1] = q1[0].data;
    end else req[1] = 1'b0;
  end

  // Reference model: picks a winner per edge from the sampled requests, keeps a
  // shadow memory and remembers which read returns in the following cycle.
  logic          e_gnt0 = 0, e_gnt1 = 0, e_wr = 0, e_rd = 0, e_rv0 = 0, e_rv1 = 0;
  logic [AW-1:0] e_wa = '0, e_ra = '0;
  logic [DW-1:0] e_din = '0, e_rdata = '0, pend_data = '0;
  int            pend_own = -1;
  int            last = 1;
  bit            fresh = 1;
  int            win;
  bit            c0, c1;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_gnt0 = 0; e_gnt1 = 0; e_wr = 0; e_rd = 0; e_rv0 = 0; e_rv1 = 0;
      e_wa = '0; e_ra = '0; e_din = '0; e_rdata = '0;
      pend_own = -1; last = 1; fresh = 1;
    end else begin
      e_rv0   = (pend_own == 0);
      e_rv1   = (pend_own == 1);
      e_rdata = pend_data;
      pend_own = -1;
      win = -1;
      if (!fresh) begin
        c0 = req[0] && !e_gnt0;
        c1 = req[1] && !e_gnt1;
        if (c0 && c1) win = 1 - last;
        else if (c0)  win = 0;
        else if (c1)  win = 1;
      end
      fresh  = 0;
      e_gnt0 = (win == 0);
      e_gnt1 = (win == 1);
      e_wr = 0;
      e_rd = 0;
      if (win >= 0) begin
        last = win;
        if (we[win]) begin
          e_wr = 1; e_wa = addr[win]; e_din = wdata[win];
          smem[addr[win]] = wdata[win];
        end else begin
          e_rd = 1; e_ra = addr[win];
          pend_own = win; pend_data = smem[addr[win]];
        end
      end
    end
  end

  // Compare every output against the model on each falling edge.
  always @(negedge clk) begin
    check("gnt0",        32'(gnt0),        32'(e_gnt0));
    check("gnt1",        32'(gnt1),        32'(e_gnt1));
    check("mem_wr_en",   32'(mem_wr_en),   32'(e_wr));
    check("mem_rd_en",   32'(mem_rd_en),   32'(e_rd));
    check("mem_wr_addr", 32'(mem_wr_addr), 32'(e_wa));
    check("mem_rd_addr", 32'(mem_rd_addr), 32'(e_ra));
    check("mem_data_in", 32'(mem_data_in), 32'(e_din));
    check("rvalid0",     32'(rvalid0),     32'(e_rv0));
    check("rvalid1",     32'(rvalid1),     32'(e_rv1));
    check("rdata0",      32'(rdata0),      e_rv0 ? 32'(e_rdata) : 32'd0);
    check("rdata1",      32'(rdata1),      e_rv1 ? 32'(e_rdata) : 32'd0);
    check("wr_rd_excl",  32'(mem_wr_en & mem_rd_en), 32'd0);
  end

  task automatic wait_drain();
    int n = 0;
    while ((q0.size() > 0 || q1.size() > 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", 32'(n >= 200), 32'd0);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_gnt0();
    int n = 0;
    do begin @(negedge clk); n++; end while (!gnt0 && n < 30);
    check("gnt0_timeout", 32'(gnt0), 32'd1);
  endtask

  task automatic wait_rv1();
    int n = 0;
    do begin @(negedge clk); n++; end while (!rvalid1 && n < 30);
    check("rvalid1_timeout", 32'(rvalid1), 32'd1);
  endtask

  initial begin
    int n0, n1, consec, first, lastc, seen_rv, ncmd, bad11, alt_bad, gaps;
    int seq[$];
    logic prev;

    rst_n = 1'b1;
    req = '0; we = '0;
    addr[0] = '0; addr[1] = '0; wdata[0] = '0; wdata[1] = '0;
    #1 rst_n = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_gnt0",      32'(gnt0),        32'd0);
    check("rst_rd_en",     32'(mem_rd_en),   32'd0);
    check("rst_wr_addr",   32'(mem_wr_addr), 32'd0);

    // Tie after reset: both reads, requests already present at release.
    q0.push_back('{1'b0, 4'd3, 4'd0, 0});
    q1.push_back('{1'b0, 4'd5, 4'd0, 0});
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("first_edge_no_gnt", 32'({gnt0, gnt1}), 32'd0);
    @(negedge clk);
    check("tie_gnt0",    32'({gnt0, gnt1}), 32'b10);
    check("tie_rdaddr3", 32'(mem_rd_addr),  32'd3);
    @(negedge clk);
    check("tie_gnt1",    32'({gnt0, gnt1}), 32'b01);
    check("tie_rdaddr5", 32'(mem_rd_addr),  32'd5);
    check("tie_rv0",     32'(rvalid0),      32'd1);
    check("tie_rdata0",  32'(rdata0),       32'hC);
    @(negedge clk);
    check("tie_rv1",     32'({rvalid0, rvalid1}), 32'b01);
    check("tie_rdata1",  32'(rdata1),       32'hA);
    wait_drain();

    // Write then read of the same address.
    q0.push_back('{1'b1, 4'd7, 4'hA, 0});
    q1.push_back('{1'b0, 4'd7, 4'd0, 0});
    wait_rv1();
    check("wr_rd_data", 32'(rdata1), 32'hA);
    wait_drain();

    // Solo stream of four reads from requester 0.
    q0.push_back('{1'b0, 4'd1, 4'd0, 0});
    q0.push_back('{1'b0, 4'd2, 4'd0, 0});
    q0.push_back('{1'b0, 4'd4, 4'd0, 0});
    q0.push_back('{1'b0, 4'd6, 4'd0, 0});
    n0 = 0; consec = 0; prev = 1'b0; first = -1; lastc = -1;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      if (gnt0) begin
        n0++;
        if (first < 0) first = i;
        lastc = i;
      end
      if (gnt0 && prev) consec++;
      prev = gnt0;
    end
    check("solo_count",  32'(n0),     32'd4);
    check("solo_consec", 32'(consec), 32'd0);
    check("solo_span",   32'(lastc - first), 32'd6);
    wait_drain();

    // Fairness: both requesters stream ten transactions each.
    for (int i = 0; i < 10; i++) begin
      q0.push_back('{1'(i % 2), 4'(i), 4'(i + 1), 0});
      q1.push_back('{1'b0, 4'(i + 3), 4'd0, 0});
    end
    seq.delete();
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      seq.push_back(gnt0 ? 0 : (gnt1 ? 1 : -1));
    end
    n0 = 0; n1 = 0; first = -1; lastc = -1; alt_bad = 0; gaps = 0;
    for (int i = 0; i < 40; i++) begin
      if (seq[i] == 0) n0++;
      if (seq[i] == 1) n1++;
      if (seq[i] >= 0) begin
        if (first < 0) first = i;
        lastc = i;
      end
    end
    for (int i = first + 1; i <= lastc && first >= 0; i++) begin
      if (seq[i] < 0) gaps++;
      else if (seq[i] == seq[i-1]) alt_bad++;
    end
    check("fair_n0",   32'(n0),      32'd10);
    check("fair_n1",   32'(n1),      32'd10);
    check("fair_span", 32'(lastc - first + 1), 32'd20);
    check("fair_gaps", 32'(gaps),    32'd0);
    check("fair_alt",  32'(alt_bad), 32'd0);
    wait_drain();

    // Reset asserted during the grant cycle of a read.
    q0.push_back('{1'b0, 4'd2, 4'd0, 0});
    wait_gnt0();
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_gnt0",    32'(gnt0),        32'd0);
    check("mid_rst_rd_en",   32'(mem_rd_en),   32'd0);
    check("mid_rst_rd_addr", 32'(mem_rd_addr), 32'd0);
    q0.delete(); q1.delete(); age0 = 0; age1 = 0;
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    seen_rv = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (rvalid0 || rvalid1) seen_rv++;
    end
    check("mid_rst_no_rv", 32'(seen_rv), 32'd0);
    q0.push_back('{1'b0, 4'd4, 4'd0, 0});
    q1.push_back('{1'b0, 4'd8, 4'd0, 0});
    begin
      int n = 0;
      do begin @(negedge clk); n++; end while (!(gnt0 || gnt1) && n < 30);
    end
    check("post_rst_tie", 32'({gnt0, gnt1}), 32'b10);
    wait_drain();

    // Cancel: requester 1 pulses for one edge and loses the tie.
    q0.push_back('{1'b0, 4'd9,  4'd0, 0});
    q1.push_back('{1'b0, 4'd11, 4'd0, 1});
    n1 = 0; ncmd = 0; bad11 = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (gnt1) n1++;
      if (mem_rd_en || mem_wr_en) ncmd++;
      if (mem_rd_en && mem_rd_addr == 4'd11) bad11++;
    end
    check("cancel_no_gnt1", 32'(n1),    32'd0);
    check("cancel_cmds",    32'(ncmd),  32'd1);
    check("cancel_addr",    32'(bad11), 32'd0);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: DATA_W, default 4, data width of every data port.
REQ-002 Parameter: ADDR_W, default 4, address width of every address port (depth 2**ADDR_W = 16).
REQ-003 One clock; reset is asynchronous and active-low. Ports are named clk and rst_n.
REQ-004 clk  in  1  clock; all state updates on rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 req0 / req1  in  1  requester k has a transaction pending.
REQ-007 we0 / we1  in  1  1 = write, 0 = read; held stable while req_k is high.
REQ-008 addr0 / addr1  in  ADDR_W  transaction address; held stable while req_k is high.
REQ-009 wdata0 / wdata1  in  DATA_W  write data; held stable while req_k is high.
REQ-010 gnt0 / gnt1  out  1  registered one-cycle pulse; the transaction is issued to memory in this cycle.
REQ-011 rvalid0 / rvalid1  out  1  registered one-cycle pulse; rdata_k is valid.
REQ-012 rdata0 / rdata1  out  DATA_W  read data; equals mem_data_out while rvalid_k = 1, otherwise 0.
REQ-013 mem_wr_en / mem_rd_en  out  1  registered memory commands; never both 1.
REQ-014 mem_wr_addr / mem_rd_addr  out  ADDR_W  registered memory addresses.
REQ-015 mem_data_in  out  DATA_W  registered write data.
REQ-016 mem_data_out  in  DATA_W  memory read data, valid in the cycle after mem_rd_en.

Function
REQ-017 Eligibility: requester k is eligible at a clock edge when req_k = 1 and gnt_k = 0 at that edge. This masking prevents a double grant for the same transaction.
REQ-018 Arbitration:
- At most one grant is issued per edge.
- One eligible requester: it wins.
- Both eligible: the requester not granted last wins (round robin).
REQ-019 Round-robin pointer: last_gnt updates only when a grant is issued.
REQ-020 Issue: when requester k wins at edge t, during cycle t+1:
- gnt_k = 1;
- if we_k = 1: mem_wr_en = 1, mem_wr_addr = addr_k, mem_data_in = wdata_k;
- if we_k = 0: mem_rd_en = 1, mem_rd_addr = addr_k.
REQ-021 No winner at an edge: in the next cycle all gnt signals are 0 and mem_wr_en / mem_rd_en are 0. Address and data outputs hold their previous values.
REQ-022 Read return: for a read granted in cycle t+1, rvalid_k = 1 in cycle t+2, and rdata_k = mem_data_out in that cycle. Latency is req sampled -> gnt: 1 cycle; gnt -> rvalid: 1 cycle.
REQ-023 Requester protocol: the requester deasserts req_k, or presents its next transaction, on the edge ending its gnt_k cycle.
REQ-024 Throughput: two requesters with continuous requests alternate grants every cycle (100% memory utilisation). A single requester gets at most one grant per 2 cycles.
REQ-025 Ordering: memory operations occur in grant order. A write granted in cycle n is visible to a read granted in cycle n+1 or later.
REQ-026 Each read produces exactly one rvalid. Writes produce no rvalid.
REQ-027 A requester dropping req_k without a grant is legal and cancels its transaction.

Reset
REQ-028 rst_n = 0 immediately forces all outputs to 0: gnt*, rvalid*, rdata*, mem_wr_en, mem_rd_en, all mem addresses, mem_data_in.
REQ-029 Reset sets last_gnt = 1, so requester 0 wins the first tie.
REQ-030 Reset mid-operation discards any pending rvalid. No grant is issued on the first edge at which rst_n = 1 is sampled.
REQ-031 This block does not drive the memory's own reset.

Verification
REQ-032 Tie after reset: req0 = req1 = 1, both reads (addr0 = 3, addr1 = 5).
- gnt0 in cycle 1 with mem_rd_addr = 3;
- gnt1 in cycle 2 with mem_rd_addr = 5;
- rvalid0 in cycle 2, rvalid1 in cycle 3.
REQ-033 Write then read: req0 writes addr 7 data 0xA; the next cycle req1 reads addr 7 -> rvalid1 with rdata1 = 0xA.
REQ-034 Solo stream: req0 held high with 4 successive reads -> gnt0 pulses every 2nd cycle, never in consecutive cycles.
REQ-035 Fairness: both requesters continuously requesting for 20 cycles -> grants alternate 0,1,0,1..., 10 each. mem_wr_en & mem_rd_en is never 1.
REQ-036 Reset mid-read: assert rst_n = 0 in the gnt cycle of a read -> no rvalid afterwards, all outputs 0, and the next tie goes to requester 0.
REQ-037 Cancel: req1 pulsed for one cycle while req0 wins the tie -> no gnt1 and no memory command for requester 1.
